// File: rtl/button_counter.sv
// Up/down/clear push-button counter: each raw button is synchronised, debounced and
// edge-detected; up/down additionally auto-repeat while held.
module button_counter #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SATURATE        = 0,
    parameter int REPEAT_DELAY    = 2_000_000,
    parameter int REPEAT_PERIOD   = 500_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             limit,
    output logic [2:0]       pressed
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0]    DEB_DONE    = CW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0]    DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]    PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
    localparam logic [WIDTH-1:0] MAX_COUNT   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Button index: 0 = up, 1 = down, 2 = clear.
    logic [2:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q  [3];
    logic [2:0]             synced;
    logic [CW-1:0]          deb_cnt [3];
    logic [2:0]             deb;
    logic [2:0]             deb_d;
    logic [2:0]             rise;

    rpt_state_t             state_q [2];
    rpt_state_t             state_d [2];
    logic [TW-1:0]          timer_q [2];
    logic [TW-1:0]          timer_d [2];
    logic [1:0]             fire;
    logic [2:0]             step_d;
    logic [2:0]             step_q;

    assign raw     = {btn_clear, btn_down, btn_up};
    assign rise    = deb & ~deb_d;
    assign pressed = deb;
    assign step_d  = {rise[2], rise[1] | fire[1], rise[0] | fire[0]};

    always_comb begin
        synced = '0;
        for (int i = 0; i < 3; i++) begin
            synced[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // The debounced level flips on the edge after the disagreement counter has reached
    // DEBOUNCE_CYCLES, so bounces shorter than that never reach deb.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i]  <= '0;
                deb_cnt[i] <= '0;
            end
            deb   <= '0;
            deb_d <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                if (synced[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_DONE) begin
                    deb[i]     <= synced[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
            deb_d <= deb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
            end
            step_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            step_q <= step_d;
        end
    end

    // Auto-repeat for up (0) and down (1). Releasing the button drops straight to IDLE
    // without a step; with REPEAT_DELAY = 0 the HOLD state never times out.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            fire[i]    = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (!deb[i]) begin
                state_d[i] = IDLE;
                timer_d[i] = '0;
            end else if (rise[i]) begin
                state_d[i] = HOLD;
                timer_d[i] = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        state_d[i] = IDLE;
                    end
                    HOLD: begin
                        if (REPEAT_DELAY != 0) begin
                            if (timer_q[i] == DELAY_LAST) begin
                                fire[i]    = 1'b1;
                                state_d[i] = REPEAT;
                                timer_d[i] = '0;
                            end else begin
                                timer_d[i] = timer_q[i] + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (timer_q[i] == PERIOD_LAST) begin
                            fire[i]    = 1'b1;
                            timer_d[i] = '0;
                        end else begin
                            timer_d[i] = timer_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        timer_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // Priority: clear > load > (up with down cancels) > up > down. Losing steps are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            limit <= 1'b0;
        end else begin
            limit <= 1'b0;
            if (step_q[2]) begin
                count <= '0;
            end else if (load) begin
                count <= load_value;
            end else if (step_q[0] && !step_q[1]) begin
                limit <= (count == MAX_COUNT);
                if (count != MAX_COUNT || SATURATE == 0) begin
                    count <= count + 1'b1;
                end
            end else if (step_q[1] && !step_q[0]) begin
                limit <= (count == '0);
                if (count != '0 || SATURATE == 0) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter: a wrapping and a saturating instance share all inputs; timed
// expectations are queued as stimulus is driven and checked on the falling clock edge.
module tb_button_counter;

    localparam int W = 8;
    localparam logic [3:0] NOPRS = 4'b0000;

    logic         clock = 1'b0;
    logic         reset;
    logic [2:0]   btn;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] count, count_s;
    logic         limit, limit_s;
    logic [2:0]   pressed, pressed_s;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int           at;
        logic [W-1:0] cnt;
        logic         lim;
        logic [W-1:0] cnt_s;
        logic         lim_s;
        logic [3:0]   prs;
        string        tag;
    } exp_t;

    typedef struct {
        logic         ld;
        logic [W-1:0] val;
        logic [W-1:0] exp;
    } vec_t;

    exp_t         exp_q[$];
    vec_t         vecs[6];
    logic [W-1:0] m;
    logic [W-1:0] ms;

    button_counter #(
        .WIDTH(W), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .SATURATE(0),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clock(clock), .reset(reset), .btn_up(btn[0]), .btn_down(btn[1]),
        .btn_clear(btn[2]), .load(load), .load_value(load_value),
        .count(count), .limit(limit), .pressed(pressed)
    );

    button_counter #(
        .WIDTH(W), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .SATURATE(1),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut_sat (
        .clock(clock), .reset(reset), .btn_up(btn[0]), .btn_down(btn[1]),
        .btn_clear(btn[2]), .load(load), .load_value(load_value),
        .count(count_s), .limit(limit_s), .pressed(pressed_s)
    );

    always #5 clock = ~clock;

    // cyc is the number of rising edges seen so far.
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: compare every expectation due at this cycle.
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (e.at < cyc) begin
                bad++;
                $display("FAIL %s: check slot missed at cycle %0d, required cycle %0d", e.tag, cyc, e.at);
            end else if (count !== e.cnt || limit !== e.lim || count_s !== e.cnt_s || limit_s !== e.lim_s ||
                         (e.prs[3] && (pressed !== e.prs[2:0] || pressed_s !== e.prs[2:0]))) begin
                bad++;
                $display("FAIL %s @%0d: got count=%h limit=%b count_sat=%h limit_sat=%b pressed=%b/%b, expected count=%h limit=%b count_sat=%h limit_sat=%b pressed=%b (checked=%b)",
                         e.tag, cyc, count, limit, count_s, limit_s, pressed, pressed_s,
                         e.cnt, e.lim, e.cnt_s, e.lim_s, e.prs[2:0], e.prs[3]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input int at, input logic lim, input logic lim_s, input logic [3:0] prs,
                        input string tag);
        exp_t e;
        e.at    = at;
        e.cnt   = m;
        e.lim   = lim;
        e.cnt_s = ms;
        e.lim_s = lim_s;
        e.prs   = prs;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    // One step landing at cycle 'at': unchanged before, new value (with limit) at, settled after.
    task automatic land(input int at, input int dir, input string tag);
        logic l, ls;
        push(at - 1, 1'b0, 1'b0, NOPRS, {tag, "_pre"});
        if (dir > 0) begin
            l  = (m == 8'hFF);
            m  = m + 8'd1;
            ls = (ms == 8'hFF);
            if (ms != 8'hFF) ms = ms + 8'd1;
        end else begin
            l  = (m == 8'h00);
            m  = m - 8'd1;
            ls = (ms == 8'h00);
            if (ms != 8'h00) ms = ms - 8'd1;
        end
        push(at, l, ls, NOPRS, tag);
        push(at + 1, 1'b0, 1'b0, NOPRS, {tag, "_post"});
    endtask

    task automatic press(input int b, input int hold);
        btn[b] = 1'b1;
        step(hold);
        btn[b] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step(1);
            n++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks still pending after %0d cycles, required 0", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic load_once(input logic [W-1:0] v, input string tag);
        load       = 1'b1;
        load_value = v;
        m          = v;
        ms         = v;
        push(cyc + 1, 1'b0, 1'b0, NOPRS, tag);
        step(1);
        load = 1'b0;
        drain(5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int e0;
        vecs[0] = '{ld: 1'b0, val: 8'h77, exp: 8'h01};
        vecs[1] = '{ld: 1'b1, val: 8'h3C, exp: 8'h3C};
        vecs[2] = '{ld: 1'b1, val: 8'hA5, exp: 8'hA5};
        vecs[3] = '{ld: 1'b0, val: 8'h11, exp: 8'hA5};
        vecs[4] = '{ld: 1'b1, val: 8'h00, exp: 8'h00};
        vecs[5] = '{ld: 1'b1, val: 8'hFF, exp: 8'hFF};

        btn        = '0;
        load       = 1'b0;
        load_value = '0;
        reset      = 1'b1;
        m          = '0;
        ms         = '0;
        step(2);
        push(3, 1'b0, 1'b0, {1'b1, 3'b000}, "reset_state");
        step(1);
        reset = 1'b0;
        drain(10);

        // Clean press: pressed rises at edge 7, count steps at edge 9, no repeat.
        e0 = cyc + 1;
        push(e0 + 6, 1'b0, 1'b0, {1'b1, 3'b000}, "s1_pressed_pre");
        push(e0 + 7, 1'b0, 1'b0, {1'b1, 3'b001}, "s1_pressed");
        land(e0 + 9, 1, "s1_up");
        push(e0 + 30, 1'b0, 1'b0, {1'b1, 3'b000}, "s1_released");
        press(0, 10);
        step(25);
        drain(50);

        // Load vectors, one cycle each; a held load reloads every cycle.
        for (int i = 0; i < 6; i++) begin
            load       = vecs[i].ld;
            load_value = vecs[i].val;
            m          = vecs[i].exp;
            ms         = vecs[i].exp;
            push(cyc + 1, 1'b0, 1'b0, NOPRS, $sformatf("load_vec%0d", i));
            step(1);
        end
        load = 1'b0;
        drain(5);

        // Increment at max: wrap to 0 / hold at FF, both with a limit pulse.
        e0 = cyc + 1;
        land(e0 + 9, 1, "up_at_max");
        press(0, 10);
        step(25);
        drain(50);

        // Bouncing contact, then a clean hold: exactly one step, 9 edges into the hold.
        e0 = cyc + 1;
        push(e0 + 15, 1'b0, 1'b0, {1'b1, 3'b000}, "bounce_no_level");
        land(e0 + 29, 1, "bounce_up");
        for (int k = 0; k < 5; k++) begin
            btn[0] = 1'b1;
            step(2);
            btn[0] = 1'b0;
            step(2);
        end
        press(0, 10);
        step(25);
        drain(80);

        // Auto-repeat: steps at 9, 29, 34, 39, 44; released before the next period.
        e0 = cyc + 1;
        land(e0 + 9, 1, "rpt_edge");
        land(e0 + 29, 1, "rpt_first");
        land(e0 + 34, 1, "rpt_2");
        land(e0 + 39, 1, "rpt_3");
        land(e0 + 44, 1, "rpt_4");
        push(e0 + 60, 1'b0, 1'b0, {1'b1, 3'b000}, "rpt_released");
        press(0, 40);
        step(30);
        drain(100);

        // Decrement at 0: wrap to FF / hold at 0, both with a limit pulse.
        load_once(8'h00, "load_zero");
        e0 = cyc + 1;
        land(e0 + 9, -1, "down_at_zero");
        press(1, 10);
        step(25);
        drain(50);

        // Up and down together cancel.
        e0 = cyc + 1;
        push(e0 + 8, 1'b0, 1'b0, {1'b1, 3'b011}, "updown_pressed");
        push(e0 + 9, 1'b0, 1'b0, NOPRS, "updown_same");
        push(e0 + 10, 1'b0, 1'b0, NOPRS, "updown_after");
        fork
            press(0, 10);
            press(1, 10);
        join
        step(25);
        drain(50);

        // Clear step coinciding with a repeat up step at edge 34: clear wins, no limit.
        e0 = cyc + 1;
        land(e0 + 9, 1, "cr_up_edge");
        land(e0 + 29, 1, "cr_up_first");
        push(e0 + 33, 1'b0, 1'b0, NOPRS, "cr_pre");
        m  = 8'h00;
        ms = 8'h00;
        push(e0 + 34, 1'b0, 1'b0, {1'b1, 3'b101}, "cr_clear_wins");
        push(e0 + 35, 1'b0, 1'b0, NOPRS, "cr_post");
        land(e0 + 39, 1, "cr_up_after");
        land(e0 + 44, 1, "cr_up_last");
        push(e0 + 60, 1'b0, 1'b0, {1'b1, 3'b000}, "cr_released");
        fork
            press(0, 40);
            begin
                step(25);
                press(2, 6);
            end
        join
        step(25);
        drain(100);

        // One-cycle reset in REPEAT with count 7 and up still held: new press after reset.
        load_once(8'h05, "load_five");
        e0 = cyc + 1;
        land(e0 + 9, 1, "rst_up_edge");
        land(e0 + 29, 1, "rst_up_first");
        m  = 8'h00;
        ms = 8'h00;
        push(e0 + 31, 1'b0, 1'b0, {1'b1, 3'b000}, "rst_cleared");
        push(e0 + 36, 1'b0, 1'b0, NOPRS, "rst_quiet");
        land(e0 + 41, 1, "rst_new_press");
        push(e0 + 65, 1'b0, 1'b0, {1'b1, 3'b000}, "rst_released");
        fork
            press(0, 45);
            begin
                step(31);
                reset = 1'b1;
                step(1);
                reset = 1'b0;
            end
        join
        step(25);
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
